pipeline_hazard_unit: RTL and testbench

//  Sequences the 5-stage datapath fed by the control decoder: stalls/flushes pipeline registers on load-use

---
 rtl/pipeline_hazard_unit.sv | 185 ++++++++++++++++++
 tb/tb_pipeline_hazard_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_unit
//  Purpose  : Hazard sequencer for the 5-stage datapath. It stalls on load-use
//             hazards, flushes on taken branches, and freezes the pipe while
//             data memory is busy. A memory timeout forces a release and
//             raises a sticky error.
//  Ports    : clk, reset (sync, active-high)
//             id_rs/id_rt/id_uses_rt        - operands of the instruction in ID
//             ex_mem_read/ex_rt             - load in EX and its destination
//             ex_branch_taken               - branch in EX resolved taken
//             mem_req/mem_ack               - MEM-stage access handshake
//             mem_error_clr                 - clears the sticky mem_error
//             pc_en, ifid_en, idex_en, exmem_en       - register enables
//             ifid_flush, idex_flush, memwb_flush     - bubble inserts
//             mem_error                     - sticky memory-timeout flag
//  Option   : HAZARD_PERF_EN adds saturating counters stall_cycles and
//             flush_count (CNT_W bits each).
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_unit #(
    parameter int MEM_TIMEOUT = 15,
    parameter int WAIT_W      = 5
`ifdef HAZARD_PERF_EN
    ,
    parameter int CNT_W       = 32
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    input  logic             mem_error_clr,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_flush,
    output logic             mem_error
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
`endif
);

    localparam logic [WAIT_W-1:0] c_MEM_TIMEOUT = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [0:0] {
        S_RUN      = 1'b0,
        S_MEM_WAIT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [WAIT_W-1:0]   r_waitCnt;
    logic [WAIT_W-1:0]   w_nextWaitCnt;
    logic                w_freeze;
    logic                w_timeout;
    logic                w_loadUse;

    // r0 is hard-wired zero, so a load targeting it can never create a hazard.
    assign w_loadUse = ex_mem_read && (ex_rt != 5'd0) &&
                       ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // Next-state / freeze decision
    always_comb begin
        w_nextState   = r_state;
        w_nextWaitCnt = r_waitCnt;
        w_freeze      = 1'b0;
        w_timeout     = 1'b0;
        case (r_state)
            S_RUN: begin
                if (mem_req && !mem_ack) begin
                    w_freeze      = 1'b1;
                    w_nextState   = S_MEM_WAIT;
                    w_nextWaitCnt = WAIT_W'(1);
                end
            end
            S_MEM_WAIT: begin
                if (mem_ack) begin
                    w_nextState   = S_RUN;
                    w_nextWaitCnt = '0;
                end else if (r_waitCnt < c_MEM_TIMEOUT) begin
                    w_freeze      = 1'b1;
                    w_nextWaitCnt = r_waitCnt + 1'b1;
                end else begin
                    // Give up on the access: release the pipe this cycle.
                    w_timeout     = 1'b1;
                    w_nextState   = S_RUN;
                    w_nextWaitCnt = '0;
                end
            end
            default: begin
                w_nextState   = S_RUN;
                w_nextWaitCnt = '0;
            end
        endcase
    end

    // Pipeline control, priority: reset > freeze > branch > load-use > normal.
    // During a freeze EX is held, so a branch or load-use there is simply
    // re-evaluated once the pipe is released.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        if (reset) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            memwb_flush = 1'b1;
        end else if (w_freeze) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (ex_branch_taken) begin
            // The load-use consumer, if any, is wrong-path and gets flushed.
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
        end else if (w_loadUse) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_flush  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_RUN;
            r_waitCnt <= '0;
            mem_error <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_waitCnt <= w_nextWaitCnt;
            // A new timeout beats a simultaneous clear.
            if (w_timeout) begin
                mem_error <= 1'b1;
            end else if (mem_error_clr) begin
                mem_error <= 1'b0;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic w_stallEvt;
    logic w_flushEvt;

    assign w_stallEvt = w_freeze || (w_loadUse && !ex_branch_taken);
    assign w_flushEvt = !w_freeze && ex_branch_taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (w_stallEvt && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (w_flushEvt && (flush_count != '1)) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_pipeline_hazard_unit
//  Purpose  : Self-checking bench for pipeline_hazard_unit: directed scenarios
//             with literal expectations, then randomized traffic compared
//             every cycle against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_unit;

    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_mem_read, ex_branch_taken;
    logic       mem_req, mem_ack, mem_error_clr;
    logic       pc_en, ifid_en, idex_en, exmem_en;
    logic       ifid_flush, idex_flush, memwb_flush, mem_error;
    logic [6:0] outs;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_unit #(.MEM_TIMEOUT(TO), .WAIT_W(5)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_error_clr(mem_error_clr),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .memwb_flush(memwb_flush), .mem_error(mem_error)
    );

    // {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush}
    assign outs = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush};

    localparam logic [6:0] O_RESET  = 7'b0000111;
    localparam logic [6:0] O_FREEZE = 7'b0000001;
    localparam logic [6:0] O_BRANCH = 7'b1111110;
    localparam logic [6:0] O_STALL  = 7'b0011010;
    localparam logic [6:0] O_NORMAL = 7'b1111000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: tracks how many cycles the current memory access
    // has already held the pipe frozen, plus the sticky error flag.
    // ------------------------------------------------------------------
    int mFrozen = 0;
    int nFrozen = 0;
    bit mErr    = 1'b0;
    bit nErr    = 1'b0;
    bit mValid  = 1'b0;

    always @(negedge clk) begin : model
        bit         lu, frz, expire;
        logic [6:0] e;
        lu = ex_mem_read && (ex_rt != 0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        if (mFrozen == 0) frz = mem_req && !mem_ack;
        else              frz = !mem_ack && (mFrozen < TO);
        expire = (mFrozen > 0) && !mem_ack && !frz;

        if (reset)                e = O_RESET;
        else if (frz)             e = O_FREEZE;
        else if (ex_branch_taken) e = O_BRANCH;
        else if (lu)              e = O_STALL;
        else                      e = O_NORMAL;

        check("outs", 32'(outs), 32'(e));
        if (mValid) check("mem_error", 32'(mem_error), 32'(mErr));

        if (reset) begin
            nFrozen = 0;
            nErr    = 1'b0;
        end else begin
            nFrozen = frz ? mFrozen + 1 : 0;
            nErr    = expire ? 1'b1 : (mem_error_clr ? 1'b0 : mErr);
        end
    end

    always @(posedge clk) begin
        mFrozen = nFrozen;
        mErr    = nErr;
        if (reset) mValid = 1'b1;
    end

    task automatic nextCyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        reset = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_mem_read = 0;
        ex_rt = 0; ex_branch_taken = 0; mem_req = 0; mem_ack = 0; mem_error_clr = 0;
    endtask

    bit slow;
    int nfrz;

    initial begin
        idle();
        reset = 1;
        @(negedge clk); check("reset_outs", 32'(outs), 32'(O_RESET));
        nextCyc();
        @(negedge clk); check("reset_outs2", 32'(outs), 32'(O_RESET));
        check("reset_err", 32'(mem_error), 32'd0);
        nextCyc();

        // Load-use stall on rs, then normal flow
        idle(); ex_mem_read = 1; ex_rt = 5; id_rs = 5;
        @(negedge clk); check("t1_stall", 32'(outs), 32'(O_STALL));
        nextCyc();
        ex_mem_read = 0;
        @(negedge clk); check("t1_after", 32'(outs), 32'(O_NORMAL));
        nextCyc();

        // r0 exempt; rt only matters when the instruction reads rt
        idle(); ex_mem_read = 1; ex_rt = 0; id_rs = 0;
        @(negedge clk); check("t2_r0", 32'(outs), 32'(O_NORMAL));
        nextCyc();
        ex_rt = 3; id_rt = 3; id_rs = 1; id_uses_rt = 0;
        @(negedge clk); check("t2_no_rt", 32'(outs), 32'(O_NORMAL));
        nextCyc();
        id_uses_rt = 1;
        @(negedge clk); check("t2_rt", 32'(outs), 32'(O_STALL));
        nextCyc();

        // Branch wins over load-use
        ex_branch_taken = 1;
        @(negedge clk); check("t3_branch", 32'(outs), 32'(O_BRANCH));
        nextCyc();

        // Memory wait: ack on the 4th cycle, branch ignored while frozen
        idle(); mem_req = 1; ex_branch_taken = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); check("t4_freeze", 32'(outs), 32'(O_FREEZE));
            nextCyc();
        end
        mem_ack = 1; ex_branch_taken = 0;
        @(negedge clk); check("t4_release", 32'(outs), 32'(O_NORMAL));
        nextCyc();
        idle();
        @(negedge clk); check("t4_err", 32'(mem_error), 32'd0);
        nextCyc();

        // Timeout: 15 frozen cycles, forced release, sticky error (set beats clr)
        idle(); mem_req = 1;
        for (int i = 0; i < TO; i++) begin
            @(negedge clk); check("t5_freeze", 32'(outs), 32'(O_FREEZE));
            nextCyc();
        end
        mem_error_clr = 1;
        @(negedge clk); check("t5_release", 32'(outs), 32'(O_NORMAL));
        check("t5_err_pre", 32'(mem_error), 32'd0);
        nextCyc();
        idle();
        @(negedge clk); check("t5_err_set", 32'(mem_error), 32'd1);
        nextCyc();
        @(negedge clk); check("t5_err_hold", 32'(mem_error), 32'd1);
        nextCyc();
        mem_error_clr = 1;
        @(negedge clk); check("t5_err_clr0", 32'(mem_error), 32'd1);
        nextCyc();
        mem_error_clr = 0;
        @(negedge clk); check("t5_err_clr1", 32'(mem_error), 32'd0);
        nextCyc();

        // Reset in the second wait cycle abandons the access
        idle(); mem_req = 1;
        @(negedge clk); check("t6_freeze", 32'(outs), 32'(O_FREEZE));
        nextCyc();
        reset = 1;
        @(negedge clk); check("t6_reset", 32'(outs), 32'(O_RESET));
        nextCyc();
        idle();
        @(negedge clk); check("t6_run", 32'(outs), 32'(O_NORMAL));
        nextCyc();
        // A fresh access must get the full timeout budget again
        mem_req = 1;
        nfrz = 0;
        for (int i = 0; i < TO + 1; i++) begin
            @(negedge clk); if (outs === O_FREEZE) nfrz++;
            nextCyc();
        end
        check("t6_fresh_budget", 32'(nfrz), 32'(TO));
        idle(); mem_error_clr = 1;
        nextCyc();

        // Randomized traffic; every third 200-cycle window acks rarely
        for (int i = 0; i < 3000; i++) begin
            slow            = ((i / 200) % 3) == 2;
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            ex_rt           = 5'($urandom_range(0, 3));
            id_uses_rt      = 1'($urandom_range(0, 1));
            ex_mem_read     = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 4) == 0);
            mem_req         = slow ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 2) == 0);
            mem_ack         = slow ? ($urandom_range(0, 31) == 0) : ($urandom_range(0, 2) == 0);
            mem_error_clr   = ($urandom_range(0, 19) == 0);
            reset           = ($urandom_range(0, 99) == 0);
            nextCyc();
        end

        idle();
        nextCyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
